serv_bus_arbiter: RTL and testbench

SERV_BUS_ARBITER -- requirements
Module: serv_bus_arbiter

---
 rtl/serv_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_serv_bus_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_bus_arbiter.sv
// serv_bus_arbiter: shares one Wishbone master port between SERV ibus and dbus.
// Ties alternate between masters; every grant is followed by an idle turnaround.
module serv_bus_arbiter #(
    parameter int TIMEOUT_W    = 8,
    parameter int WITH_TIMEOUT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    output logic        o_ibus_err,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic        o_dbus_err,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack
);

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D
    } state_t;

    localparam bit TMO_EN = (WITH_TIMEOUT != 0);

    state_t               state;
    state_t               state_d;
    logic                 last_d;
    logic                 last_d_d;
    logic [TIMEOUT_W-1:0] cnt;
    logic [TIMEOUT_W-1:0] cnt_d;
    logic                 tmo;

    assign tmo        = TMO_EN && (cnt == '1);
    assign o_ibus_rdt = i_wb_rdt;
    assign o_dbus_rdt = i_wb_rdt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            last_d <= 1'b1;
            cnt    <= '0;
        end else begin
            state  <= state_d;
            last_d <= last_d_d;
            cnt    <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        last_d_d   = last_d;
        cnt_d      = '0;
        o_ibus_ack = 1'b0;
        o_ibus_err = 1'b0;
        o_dbus_ack = 1'b0;
        o_dbus_err = 1'b0;
        o_wb_adr   = '0;
        o_wb_dat   = '0;
        o_wb_sel   = '0;
        o_wb_we    = 1'b0;
        o_wb_cyc   = 1'b0;
        unique case (state)
            IDLE: begin
                // On a tie the master that did not win last time goes first
                if (i_ibus_cyc && (!i_dbus_cyc || last_d)) begin
                    state_d  = GNT_I;
                    last_d_d = 1'b0;
                end else if (i_dbus_cyc) begin
                    state_d  = GNT_D;
                    last_d_d = 1'b1;
                end
            end
            GNT_I: begin
                o_wb_adr = i_ibus_adr;
                o_wb_sel = 4'hf;
                o_wb_cyc = i_ibus_cyc;
                if (i_wb_ack) begin
                    o_ibus_ack = 1'b1;
                    state_d    = IDLE;
                end else if (!i_ibus_cyc) begin
                    state_d = IDLE;
                end else if (tmo) begin
                    o_ibus_ack = 1'b1;
                    o_ibus_err = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            GNT_D: begin
                o_wb_adr = i_dbus_adr;
                o_wb_dat = i_dbus_dat;
                o_wb_sel = i_dbus_sel;
                o_wb_we  = i_dbus_we;
                o_wb_cyc = i_dbus_cyc;
                if (i_wb_ack) begin
                    o_dbus_ack = 1'b1;
                    state_d    = IDLE;
                end else if (!i_dbus_cyc) begin
                    state_d = IDLE;
                end else if (tmo) begin
                    o_dbus_ack = 1'b1;
                    o_dbus_err = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// tb_serv_bus_arbiter: random two-master traffic against a transaction-level model.
// Expected completions are queued at issue time and retired by the monitor.
module tb_serv_bus_arbiter;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        bit          tmo;
        bit          drop;
    } txn_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] ibus_adr;
    logic        ibus_cyc;
    logic [31:0] ibus_rdt;
    logic        ibus_ack;
    logic        ibus_err;
    logic [31:0] dbus_adr;
    logic [31:0] dbus_dat;
    logic [3:0]  dbus_sel;
    logic        dbus_we;
    logic        dbus_cyc;
    logic [31:0] dbus_rdt;
    logic        dbus_ack;
    logic        dbus_err;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic [31:0] wb_rdt;
    logic        wb_ack;

    int vectors;
    int miscompares;

    txn_t iq[$];
    txn_t dq[$];

    serv_bus_arbiter #(
        .TIMEOUT_W   (4),
        .WITH_TIMEOUT(1)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_ibus_adr(ibus_adr),
        .i_ibus_cyc(ibus_cyc),
        .o_ibus_rdt(ibus_rdt),
        .o_ibus_ack(ibus_ack),
        .o_ibus_err(ibus_err),
        .i_dbus_adr(dbus_adr),
        .i_dbus_dat(dbus_dat),
        .i_dbus_sel(dbus_sel),
        .i_dbus_we (dbus_we),
        .i_dbus_cyc(dbus_cyc),
        .o_dbus_rdt(dbus_rdt),
        .o_dbus_ack(dbus_ack),
        .o_dbus_err(dbus_err),
        .o_wb_adr  (wb_adr),
        .o_wb_dat  (wb_dat),
        .o_wb_sel  (wb_sel),
        .o_wb_we   (wb_we),
        .o_wb_cyc  (wb_cyc),
        .i_wb_rdt  (wb_rdt),
        .i_wb_ack  (wb_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] hash(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'ha5c3_0f96;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_note(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got no event, expected event @%0t", name, $time);
    endtask

    // Slave: 0 = random latency + stray idle acks, 1 = never ack, 2 = ack whenever idle
    int slave_mode;
    bit s_busy;
    int s_wait;

    always begin
        @(posedge clk);
        #2;
        if (slave_mode == 1) begin
            s_busy = 0;
            wb_ack = 1'b0;
            wb_rdt = $urandom;
        end else if (wb_cyc) begin
            if (!s_busy) begin
                s_busy = 1;
                s_wait = $urandom_range(0, 3);
            end
            if (s_wait == 0) begin
                wb_ack = 1'b1;
                wb_rdt = hash(wb_adr);
                s_busy = 0;
            end else begin
                wb_ack = 1'b0;
                wb_rdt = $urandom;
                s_wait--;
            end
        end else begin
            s_busy = 0;
            wb_rdt = $urandom;
            wb_ack = (slave_mode == 2) || ($urandom_range(0, 3) == 0);
        end
    end

    // Reference model: grants decided from requests seen in an idle cycle
    bit          busy;
    bit          pend;
    bit          own_d;
    bit          pend_d;
    bit          last_own_d;
    int          age;
    txn_t        t;
    logic        m_ack;
    logic        m_err;
    logic [31:0] m_rdt;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_cyc", 64'(wb_cyc), 64'd0);
            chk("rst_ackerr", 64'({ibus_ack, ibus_err, dbus_ack, dbus_err}), 64'd0);
            chk("rst_bus", 64'({wb_adr, wb_sel, wb_we}), 64'd0);
            iq.delete();
            dq.delete();
            busy       = 0;
            pend       = 0;
            last_own_d = 1;
        end else begin
            if (pend) begin
                busy  = 1;
                own_d = pend_d;
                age   = 0;
                pend  = 0;
            end else if (busy) begin
                age++;
            end
            if (busy) begin
                if (own_d)
                    chk("nonowner_i", 64'({ibus_ack, ibus_err}), 64'd0);
                else
                    chk("nonowner_d", 64'({dbus_ack, dbus_err}), 64'd0);
                if ((own_d ? dq.size() : iq.size()) == 0) begin
                    fail_note("grant_without_request");
                    busy = 0;
                end else begin
                    t     = own_d ? dq[0] : iq[0];
                    m_ack = own_d ? dbus_ack : ibus_ack;
                    m_err = own_d ? dbus_err : ibus_err;
                    m_rdt = own_d ? dbus_rdt : ibus_rdt;
                    if (wb_cyc) begin
                        chk(own_d ? "d_adr" : "i_adr", 64'(wb_adr), 64'(t.adr));
                        chk(own_d ? "d_dat" : "i_dat", 64'(wb_dat), 64'(t.dat));
                        chk(own_d ? "d_selwe" : "i_selwe",
                            64'({wb_sel, wb_we}), 64'({t.sel, t.we}));
                    end
                    if (m_ack) begin
                        chk(own_d ? "d_err" : "i_err", 64'(m_err), 64'(t.tmo));
                        chk("ack_not_drop", 64'(t.drop), 64'd0);
                        if (t.tmo)
                            chk("tmo_cycle", 64'(age), 64'd15);
                        else
                            chk(own_d ? "d_rdt" : "i_rdt", 64'(m_rdt), 64'(hash(t.adr)));
                        if (own_d) void'(dq.pop_front());
                        else void'(iq.pop_front());
                        busy = 0;
                    end else if (!wb_cyc) begin
                        chk("drop_expected", 64'(t.drop), 64'd1);
                        chk("drop_err", 64'(m_err), 64'd0);
                        if (own_d) void'(dq.pop_front());
                        else void'(iq.pop_front());
                        busy = 0;
                    end
                end
            end else begin
                chk("idle_cyc", 64'(wb_cyc), 64'd0);
                chk("idle_ackerr", 64'({ibus_ack, ibus_err, dbus_ack, dbus_err}), 64'd0);
                chk("idle_adr", 64'(wb_adr), 64'd0);
                chk("idle_ctl", 64'({wb_dat, wb_sel, wb_we}), 64'd0);
                if (ibus_cyc || dbus_cyc) begin
                    pend = 1;
                    if (ibus_cyc && dbus_cyc) pend_d = !last_own_d;
                    else pend_d = dbus_cyc;
                    last_own_d = pend_d;
                end
            end
        end
    end

    // One transaction; returns at posedge+1 after the ack with cyc still high
    task automatic issue(input bit d, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, input bit tmo, input bit drop);
        txn_t e;
        int   n;
        bit   got;
        e.adr  = adr;
        e.dat  = d ? dat : 32'd0;
        e.sel  = d ? sel : 4'hf;
        e.we   = d ? we : 1'b0;
        e.tmo  = tmo;
        e.drop = drop;
        if (d) begin
            dbus_adr = adr;
            dbus_dat = dat;
            dbus_sel = sel;
            dbus_we  = we;
            dbus_cyc = 1'b1;
            dq.push_back(e);
        end else begin
            ibus_adr = adr;
            ibus_cyc = 1'b1;
            iq.push_back(e);
        end
        if (!drop) begin
            n   = 0;
            got = 0;
            while (!got && n < 100) begin
                @(negedge clk);
                got = d ? dbus_ack : ibus_ack;
                n++;
            end
            if (!got) fail_note(d ? "d_ack_wait" : "i_ack_wait");
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_master(input bit d, input int n, input int maxgap);
        for (int k = 0; k < n; k++) begin
            int gap;
            gap = $urandom_range(0, maxgap);
            if (gap != 0) begin
                if (d) dbus_cyc = 1'b0;
                else ibus_cyc = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            issue(d, $urandom, $urandom, 4'($urandom), 1'($urandom), 0, 0);
        end
        if (d) dbus_cyc = 1'b0;
        else ibus_cyc = 1'b0;
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_cyc && n < 50);
        if (!wb_cyc) fail_note("grant_wait");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        slave_mode  = 0;
        rst_n       = 1'b0;
        ibus_adr    = '0;
        ibus_cyc    = 1'b0;
        dbus_adr    = '0;
        dbus_dat    = '0;
        dbus_sel    = '0;
        dbus_we     = 1'b0;
        dbus_cyc    = 1'b0;
        wb_rdt      = '0;
        wb_ack      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Both masters request on the same edge: ibus first, then dbus
        fork
            begin
                issue(0, 32'h0000_0100, 32'd0, 4'h0, 1'b0, 0, 0);
                ibus_cyc = 1'b0;
            end
            begin
                issue(1, 32'h0000_2000, 32'h1234_5678, 4'hf, 1'b0, 0, 0);
                dbus_cyc = 1'b0;
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // Directed store
        issue(1, 32'h0000_1000, 32'hdead_beef, 4'b0011, 1'b1, 0, 0);
        dbus_cyc = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Random traffic with gaps, then back-to-back alternation
        fork
            run_master(0, 25, 2);
            run_master(1, 25, 2);
        join
        fork
            run_master(0, 8, 0);
            run_master(1, 8, 0);
        join
        repeat (2) @(posedge clk);
        #1;

        // Bus timeout on dbus
        slave_mode = 1;
        issue(1, 32'h0000_3000, 32'h0, 4'hf, 1'b0, 1, 0);
        dbus_cyc = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Stray acks while idle
        slave_mode = 2;
        repeat (5) @(posedge clk);
        #1;

        // dbus abandons its request mid-grant
        slave_mode = 1;
        issue(1, 32'h0000_4000, 32'h0, 4'hf, 1'b0, 0, 1);
        wait_grant();
        repeat (2) @(posedge clk);
        #1;
        dbus_cyc = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset during a dbus grant while ibus waits
        issue(1, 32'h0000_5000, 32'h0, 4'hf, 1'b0, 0, 1);
        wait_grant();
        @(posedge clk);
        #1;
        ibus_cyc = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("async_rst_cyc", 64'(wb_cyc), 64'd0);
        chk("async_rst_ack", 64'({ibus_ack, dbus_ack}), 64'd0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        slave_mode = 0;
        fork
            begin
                issue(0, 32'h0000_6000, 32'd0, 4'h0, 1'b0, 0, 0);
                ibus_cyc = 1'b0;
            end
            begin
                issue(1, 32'h0000_7000, 32'h0bad_f00d, 4'h5, 1'b1, 0, 0);
                dbus_cyc = 1'b0;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        chk("iq_drained", 64'(iq.size()), 64'd0);
        chk("dq_drained", 64'(dq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
